// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_arb_pkg: shared FSM encoding, port indices and default widths for dmem_port_arbiter
package dmem_arb_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int P_CORE = 0;
  localparam int P_DBG = 1;
  typedef enum logic [2:0] {RUN, DRAIN, ISSUE, HOLD, WAIT} arb_state_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: requester-side and memory-side bus of the data-port arbiter
//   i_req/i_we/i_ben/i_addr/i_wdata [p] : per-port request fields
//   o_gnt/o_rvalid [p], o_rdata         : per-port grant, read response (shared data)
//   o_mem_* / i_mem_rdata / i_mem_ready : single memory port
//   slave modport = arbiter view, master modport = requester/memory model view
interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int BW = DATA_W / 8;
  logic [1:0]             i_req;
  logic [1:0]             i_we;
  logic [1:0][BW-1:0]     i_ben;
  logic [1:0][ADDR_W-1:0] i_addr;
  logic [1:0][DATA_W-1:0] i_wdata;
  logic [1:0]             o_gnt;
  logic [1:0]             o_rvalid;
  logic [DATA_W-1:0]      o_rdata;
  logic                   o_mem_ren;
  logic                   o_mem_wen;
  logic [BW-1:0]          o_mem_ben;
  logic [ADDR_W-1:0]      o_mem_addr;
  logic [DATA_W-1:0]      o_mem_wdata;
  logic [DATA_W-1:0]      i_mem_rdata;
  logic                   i_mem_ready;
  modport slave (
    input  i_req, i_we, i_ben, i_addr, i_wdata, i_mem_rdata, i_mem_ready,
    output o_gnt, o_rvalid, o_rdata, o_mem_ren, o_mem_wen, o_mem_ben, o_mem_addr, o_mem_wdata
  );
  modport master (
    output i_req, i_we, i_ben, i_addr, i_wdata, i_mem_rdata, i_mem_ready,
    input  o_gnt, o_rvalid, o_rdata, o_mem_ren, o_mem_wen, o_mem_ben, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin picker with fixed-priority override
//   i_req[1:0]  requests        i_advance  grants allowed this cycle
//   i_fixed     port 0 always wins a tie
//   o_gnt[1:0]  one-hot grant; pointer flips away from the last granted port
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  input  logic       i_fixed,
  output logic [1:0] o_gnt
);
  logic r_ptr;
  always_comb o_gnt = !i_advance ? 2'b00 :
                      (i_req == 2'b11) ? ((i_fixed || !r_ptr) ? 2'b01 : 2'b10) : i_req;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= 1'b0;
    else if (|o_gnt) r_ptr <= o_gnt[0];
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: arbitrates core (port 0) and debug (port 1) onto one SPRAM data port
//   i_clk, i_rst_n (async active-low), bus (dmem_port_arbiter_if.slave)
//   DMEM_ARB_FENCE_EN adds i_fence_req / o_fence_ack / o_mem_fence_i and the fence FSM
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit FIXED_P0 = 1'b0
) (
  input logic i_clk,
  input logic i_rst_n,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_FENCE_EN
  ,
  input  logic i_fence_req,
  output logic o_fence_ack,
  output logic o_mem_fence_i
`endif
);
  logic [1:0] w_gnt;
  logic       w_en;
  logic       w_sel;
  logic       w_rd;
  logic       r_pend;
  logic       r_tag;
`ifdef DMEM_ARB_FENCE_EN
  arb_state_t r_state;
  logic       r_fence_i;
  // a fence request blocks grants in the very cycle it is seen
  always_comb w_en = bus.i_mem_ready && (r_state == RUN) && !i_fence_req;
  always_comb o_mem_fence_i = r_fence_i;
  always_comb o_fence_ack = (r_state == WAIT) && bus.i_mem_ready;
  // the response in flight during RUN returns that same cycle, so DRAIN only
  // holds off ISSUE when a read would still be outstanding
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= RUN;
      r_fence_i <= 1'b0;
    end else begin
      r_fence_i <= 1'b0;
      case (r_state)
        RUN:     if (i_fence_req) begin
                   r_state   <= w_rd ? DRAIN : ISSUE;
                   r_fence_i <= !w_rd;
                 end
        DRAIN:   if (!r_pend) begin
                   r_state   <= ISSUE;
                   r_fence_i <= 1'b1;
                 end
        ISSUE:   r_state <= HOLD;
        HOLD:    r_state <= WAIT;
        WAIT:    if (bus.i_mem_ready) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
`else
  always_comb w_en = bus.i_mem_ready;
`endif
  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (bus.i_req),
    .i_advance(w_en),
    .i_fixed  (FIXED_P0),
    .o_gnt    (w_gnt)
  );
  always_comb begin
    w_sel           = w_gnt[P_DBG];
    w_rd            = |w_gnt && !bus.i_we[w_sel];
    bus.o_gnt       = w_gnt;
    bus.o_mem_ren   = w_rd;
    bus.o_mem_wen   = |w_gnt && bus.i_we[w_sel];
    bus.o_mem_ben   = |w_gnt ? bus.i_ben[w_sel] : '0;
    bus.o_mem_addr  = |w_gnt ? bus.i_addr[w_sel] : '0;
    bus.o_mem_wdata = |w_gnt ? bus.i_wdata[w_sel] : '0;
    bus.o_rvalid    = r_pend ? (r_tag ? 2'b10 : 2'b01) : 2'b00;
    bus.o_rdata     = r_pend ? bus.i_mem_rdata : '0;
  end
  // tag of the read granted last cycle steers the 1-cycle-latency response
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pend <= 1'b0;
      r_tag  <= 1'b0;
    end else begin
      r_pend <= w_rd;
      r_tag  <= w_sel;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of round-robin and fixed-priority arbiter instances
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
`ifdef DMEM_ARB_FENCE_EN
  logic fence_req = 1'b0;
  logic ack0, fi0, ack1, fi1;
`endif
  always #5 clk = ~clk;
  dmem_port_arbiter_if b0 ();
  dmem_port_arbiter_if b1 ();
  assign b1.i_req       = b0.i_req;
  assign b1.i_we        = b0.i_we;
  assign b1.i_ben       = b0.i_ben;
  assign b1.i_addr      = b0.i_addr;
  assign b1.i_wdata     = b0.i_wdata;
  assign b1.i_mem_rdata = b0.i_mem_rdata;
  assign b1.i_mem_ready = b0.i_mem_ready;
  dmem_port_arbiter #(.FIXED_P0(1'b0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b0)
`ifdef DMEM_ARB_FENCE_EN
    , .i_fence_req(fence_req), .o_fence_ack(ack0), .o_mem_fence_i(fi0)
`endif
  );
  dmem_port_arbiter #(.FIXED_P0(1'b1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1)
`ifdef DMEM_ARB_FENCE_EN
    , .i_fence_req(fence_req), .o_fence_ack(ack1), .o_mem_fence_i(fi1)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  initial begin
    b0.i_req = 2'b00;
    b0.i_we = 2'b00;
    b0.i_ben = '0;
    b0.i_addr = '0;
    b0.i_wdata = '0;
    b0.i_mem_rdata = '0;
    b0.i_mem_ready = 1'b1;
    nxt;
    nxt;
    rst_n = 1'b1;
    smp;
    chk("rst_gnt", b0.o_gnt, 2'b00);
    chk("rst_rvalid", b0.o_rvalid, 2'b00);
    chk("rst_ren_wen", {b0.o_mem_ren, b0.o_mem_wen}, 2'b00);
    chk("rst_rdata", b0.o_rdata, 32'h0);
    // port 0 read with 1-cycle response
    nxt;
    b0.i_req = 2'b01;
    b0.i_addr[0] = 14'h0010;
    smp;
    chk("rd_gnt", b0.o_gnt, 2'b01);
    chk("rd_ren", {b0.o_mem_ren, b0.o_mem_wen}, 2'b10);
    chk("rd_addr", b0.o_mem_addr, 14'h0010);
    nxt;
    b0.i_req = 2'b00;
    b0.i_mem_rdata = 32'hDEADBEEF;
    smp;
    chk("rd_rvalid", b0.o_rvalid, 2'b01);
    chk("rd_rdata", b0.o_rdata, 32'hDEADBEEF);
    chk("rd_gnt_idle", b0.o_gnt, 2'b00);
    // async reset during the response cycle
    nxt;
    b0.i_req = 2'b01;
    b0.i_addr[0] = 14'h0020;
    b0.i_mem_rdata = 32'h11112222;
    smp;
    chk("rstmid_gnt", b0.o_gnt, 2'b01);
    nxt;
    b0.i_req = 2'b00;
    #1 rst_n = 1'b0;
    smp;
    chk("rstmid_rvalid", b0.o_rvalid, 2'b00);
    chk("rstmid_rvalid_fix", b1.o_rvalid, 2'b00);
    chk("rstmid_rdata", b0.o_rdata, 32'h0);
    chk("rstmid_ren", b0.o_mem_ren, 1'b0);
    nxt;
    rst_n = 1'b1;
    smp;
    chk("rstpost_rvalid", b0.o_rvalid, 2'b00);
    // both ports read for 4 cycles
    nxt;
    b0.i_req = 2'b11;
    b0.i_addr[0] = 14'h0001;
    b0.i_addr[1] = 14'h0002;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("rr_gnt", b0.o_gnt, (i % 2) ? 2'b10 : 2'b01);
      chk("rr_addr", b0.o_mem_addr, (i % 2) ? 14'h0002 : 14'h0001);
      chk("fix_gnt", b1.o_gnt, 2'b01);
      if (i > 0) begin
        chk("rr_rvalid", b0.o_rvalid, (i % 2) ? 2'b01 : 2'b10);
        chk("fix_rvalid", b1.o_rvalid, 2'b01);
      end
      nxt;
    end
    b0.i_req = 2'b00;
    smp;
    chk("rr_rvalid_last", b0.o_rvalid, 2'b10);
    chk("rr_gnt_idle", b0.o_gnt, 2'b00);
    // port 1 write held across 3 not-ready cycles
    nxt;
    b0.i_req = 2'b10;
    b0.i_we = 2'b10;
    b0.i_ben[1] = 4'h5;
    b0.i_addr[1] = 14'h3FFF;
    b0.i_wdata[1] = 32'hA5A55A5A;
    b0.i_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("nrdy_gnt", b0.o_gnt, 2'b00);
      chk("nrdy_wen", {b0.o_mem_ren, b0.o_mem_wen}, 2'b00);
      nxt;
    end
    b0.i_mem_ready = 1'b1;
    smp;
    chk("wr_gnt", b0.o_gnt, 2'b10);
    chk("wr_wen", {b0.o_mem_ren, b0.o_mem_wen}, 2'b01);
    chk("wr_ben", b0.o_mem_ben, 4'h5);
    chk("wr_addr", b0.o_mem_addr, 14'h3FFF);
    chk("wr_wdata", b0.o_mem_wdata, 32'hA5A55A5A);
    nxt;
    b0.i_req = 2'b00;
    b0.i_we = 2'b00;
    smp;
    chk("wr_no_rvalid", b0.o_rvalid, 2'b00);
    // response still returns while ready is low
    nxt;
    b0.i_req = 2'b01;
    b0.i_mem_rdata = 32'hCAFEF00D;
    smp;
    chk("inf_gnt", b0.o_gnt, 2'b01);
    nxt;
    b0.i_mem_ready = 1'b0;
    smp;
    chk("inf_gnt_blk", b0.o_gnt, 2'b00);
    chk("inf_rvalid", b0.o_rvalid, 2'b01);
    chk("inf_rdata", b0.o_rdata, 32'hCAFEF00D);
    nxt;
    b0.i_mem_ready = 1'b1;
    smp;
    chk("inf_gnt_ret", b0.o_gnt, 2'b01);
    nxt;
    b0.i_req = 2'b00;
`ifdef DMEM_ARB_FENCE_EN
    smp;
    nxt;
    b0.i_req = 2'b01;
    smp;
    chk("fn_t_gnt", b0.o_gnt, 2'b01);
    nxt;
    b0.i_req = 2'b10;
    fence_req = 1'b1;
    smp;
    chk("fn_t1_gnt", b0.o_gnt, 2'b00);
    chk("fn_t1_rvalid", b0.o_rvalid, 2'b01);
    chk("fn_t1_fi", fi0, 1'b0);
    nxt;
    fence_req = 1'b0;
    smp;
    chk("fn_t2_fi", fi0, 1'b1);
    chk("fn_t2_gnt", b0.o_gnt, 2'b00);
    nxt;
    b0.i_mem_ready = 1'b0;
    smp;
    chk("fn_t3_fi", fi0, 1'b0);
    chk("fn_t3_gnt", b0.o_gnt, 2'b00);
    chk("fn_t3_ack", ack0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      nxt;
      smp;
      chk("fn_wait_ack", ack0, 1'b0);
      chk("fn_wait_gnt", b0.o_gnt, 2'b00);
    end
    nxt;
    b0.i_mem_ready = 1'b1;
    smp;
    chk("fn_t6_ack", ack0, 1'b1);
    chk("fn_t6_gnt", b0.o_gnt, 2'b00);
    nxt;
    smp;
    chk("fn_t7_ack", ack0, 1'b0);
    chk("fn_t7_gnt", b0.o_gnt, 2'b10);
    nxt;
    b0.i_req = 2'b00;
`endif
    smp;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
